// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Hart-side initiator for the byte-enabled data RAM. Accepts one load/store
//   at a time from the execute stage, drives the RAM address/width/enable/data,
//   waits out the RAM read latency, sign/zero-extends load data and returns one
//   response per request.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned half/word requests bypass the RAM and respond
//                 immediately with resp_fault=1, resp_rdata=0.
//     undefined : misaligned requests are issued as-is; resp_fault is 0.
//
// Parameters
//   XLEN          data/address width (32)
//   READ_LATENCY  clocks from RAM sampling mem_addr to mem_rdata valid (1..4)
//
// Ports
//   clock, reset_n                 clock / async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_width,
//   req_unsigned, req_addr,
//   req_wdata                      request payload
//   resp_valid/resp_ready          response handshake (held until taken)
//   resp_rdata, resp_fault         response payload
//   mem_addr, mem_wwidth,
//   mem_wenable, mem_wdata         to RAM
//   mem_rdata                      from RAM (already lane-shifted)
// ---------------------------------------------------------------------------
package load_store_unit_pkg;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  write_width_t     req_width,
  input  logic             req_unsigned,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_fault,
  output logic [XLEN-1:0]  mem_addr,
  output write_width_t     mem_wwidth,
  output logic             mem_wenable,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  state_t           r_state;
  logic             r_req_ready;
  logic             r_write;
  logic             r_unsigned;
  logic [1:0]       r_wait_cnt;
  logic [XLEN-1:0]  r_mem_addr;
  write_width_t     r_mem_wwidth;
  logic             r_mem_wenable;
  logic [XLEN-1:0]  r_mem_wdata;
  logic             r_resp_valid;
  logic [XLEN-1:0]  r_resp_rdata;
  logic [XLEN-1:0]  w_load_ext;

`ifdef MISALIGN_TRAP_EN
  logic             r_resp_fault;
  logic             w_misaligned;

  always_comb begin
    w_misaligned = ((req_width == write_halfword) && req_addr[0]) ||
                   ((req_width == write_word) && (req_addr[1:0] != 2'b00));
  end

  assign resp_fault = r_resp_fault;
`else
  assign resp_fault = 1'b0;
`endif

  // Load data arrives right-aligned; only the fill of the upper bits depends
  // on width and signedness. Word loads ignore req_unsigned.
  always_comb begin
    w_load_ext = mem_rdata;
    case (r_mem_wwidth)
      write_byte:
        w_load_ext = {{(XLEN-8){~r_unsigned & mem_rdata[7]}}, mem_rdata[7:0]};
      write_halfword:
        w_load_ext = {{(XLEN-16){~r_unsigned & mem_rdata[15]}}, mem_rdata[15:0]};
      default:
        w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_write       <= 1'b0;
      r_unsigned    <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_addr    <= '0;
      r_mem_wwidth  <= write_word;
      r_mem_wenable <= 1'b0;
      r_mem_wdata   <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
`ifdef MISALIGN_TRAP_EN
      r_resp_fault  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_unsigned  <= req_unsigned;
`ifdef MISALIGN_TRAP_EN
            // Misaligned requests never reach the RAM bus.
            if (w_misaligned) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_fault <= 1'b1;
            end else
`endif
            begin
              r_state       <= S_ACCESS;
              r_mem_addr    <= req_addr;
              r_mem_wwidth  <= req_width;
              r_mem_wdata   <= req_wdata;
              r_mem_wenable <= req_write;
            end
          end
        end

        S_ACCESS: begin
          r_mem_wenable <= 1'b0;
          if (r_write) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_state    <= S_WAIT;
            r_wait_cnt <= LAT_INIT;
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load_ext;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            r_resp_fault <= 1'b0;
`endif
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_wwidth  = r_mem_wwidth;
  assign mem_wenable = r_mem_wenable;
  assign mem_wdata   = r_mem_wdata;

endmodule
